atm_ctrl_gen2: RTL
==================

// Module: atm_ctrl_gen2
// PURPOSE
//  Parametrised ATM session controller: PIN entry with N attempts, timed lockout, menu, deposit/withdraw, PIN change.
//  Adds configurable widths, attempt count, timeouts, inactivity auto-logout, deposit saturation and exact-balance withdraw.
//  Sits between debounced one-cycle button pulses / switch inputs and the display layer; SSD decode lives downstream.
// PARAMETERS
//  PIN_W       4    PIN and switch-entry width (bits)
//  BAL_W       16   balance register width (bits)
//  MAX_TRIES   3    wrong-PIN attempts before LOCK (legal 1..7)
//  LOCK_CYC    100  cycles spent in LOCK (>=1)
//  WARN_CYC    50   cycles spent in WARNING (>=1)
//  IDLE_TO_CYC 0    inactivity cycles before auto-logout to IDLE; 0 disables
//  DEFAULT_PIN 0    PIN value loaded at reset
// PORTS
//  clk          in   1      single clock; all state changes on rising edge
//  rst_n        in   1      one clock; reset is synchronous and active-low
//  btn_ok       in   1      confirm/deposit pulse (1 cycle, debounced upstream)
//  btn_alt      in   1      PIN-change/withdraw pulse
//  btn_back     in   1      cancel/back pulse
//  sw           in   PIN_W  PIN digits or transaction amount
//  state_o      out  4      current state code (package enum)
//  tries_left   out  3      remaining PIN attempts in current entry phase
//  balance_o    out  BAL_W  current balance
//  led          out  8      status LEDs, led[7] leftmost
//  sat_o        out  1      sticky: a deposit saturated; clears on next withdraw or reset
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE, pin=DEFAULT_PIN, balance=0, tries_left=MAX_TRIES, timers 0, sat_o=0, led=8'h01.
//  Button priority when several pulse same cycle: btn_back > btn_alt > btn_ok; lower ones ignored.
//  All outputs decode from registers only; no combinational input->output path. Transitions take effect next cycle.
//  States / transitions:
//   IDLE:       ok -> PIN_ENTRY, tries_left<=MAX_TRIES.
//   PIN_ENTRY:  back -> IDLE; ok & sw==pin -> MENU; ok & sw!=pin: tries_left==1 -> LOCK else tries_left--.
//   LOCK:       stays exactly LOCK_CYC cycles (down-counter loaded on entry), then IDLE; all buttons ignored.
//   MENU:       back -> IDLE; alt -> CHG_VERIFY (tries_left<=MAX_TRIES); ok -> MONEY.
//   MONEY:      back -> MENU; ok: balance<=min(balance+sw, 2^BAL_W-1), set sat_o if clipped;
//               alt: sw<=balance -> balance-=sw (equal allowed, sw=0 no-op), clear sat_o; sw>balance -> WARNING, balance kept.
//   WARNING:    exactly WARN_CYC cycles, then MONEY; buttons ignored.
//   CHG_VERIFY: back -> MENU; ok & match -> CHG_NEW; ok & mismatch: same attempt rule as PIN_ENTRY, exhaustion -> LOCK.
//   CHG_NEW:    ok -> pin<=sw, MENU; back -> MENU, pin unchanged.
//  Inactivity: in PIN_ENTRY, MENU, MONEY, CHG_VERIFY, CHG_NEW a counter counts cycles with no button; any button
//   pulse clears it; reaching IDLE_TO_CYC forces IDLE (balance, pin kept). Not active in IDLE/LOCK/WARNING.
//   Timeout and button in same cycle: button wins, counter clears.
//  Arithmetic: sw zero-extended to BAL_W; compares unsigned; no wrap on either direction.
//  LEDs: IDLE 8'h01; PIN_ENTRY led[7]=1, led[6:0]=thermometer of failed tries; LOCK 8'hFF; MENU 8'h10;
//   MONEY 8'h02; WARNING 8'hFF; CHG_VERIFY led[2]=1, led[1:0]=failed-try thermometer (capped); CHG_NEW 8'h08.
//  Reset mid-LOCK/WARNING aborts timer immediately; pin and balance return to reset values.
// STRUCTURE
//  Package atm_pkg: state enum (4-bit), LED pattern constants, priority-decoded button enum.
//  Sub-module atm_timer: loadable down-counter (load, value, done), instanced for LOCK/WARNING and inactivity.
//  Top: next-state logic, pin/balance/tries datapath, LED decode.
// TESTING
//  1 ok, sw=pin(0), ok -> MENU in 2 cycles, led=8'h10, tries_left=3.
//  2 ok, three wrong PINs -> LOCK after 3rd, led=8'hFF for exactly 100 cycles, then IDLE; buttons in LOCK ignored.
//  3 MONEY: deposit 9 at balance 16'hFFFA -> 16'hFFFF, sat_o=1; withdraw 5 -> 16'hFFFA, sat_o=0.
//  4 MONEY, balance 7: withdraw 7 -> 0; withdraw 1 -> WARNING 50 cycles, then MONEY, balance 0.
//  5 MENU alt, right PIN, sw=4'hA ok -> MENU; logout, login with 4'hA succeeds, old PIN fails.
//  6 IDLE_TO_CYC=20: in MONEY no buttons 20 cycles -> IDLE; back+ok same cycle in MENU -> IDLE; rst_n low mid-WARNING -> IDLE.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types and helpers for the ATM session controller.
//   state_e     : 4-bit state code, also driven out on state_o
//   btn_e       : one-hot button pulses reduced to a single priority-decoded event
//   LED_*       : fixed status LED patterns
//   decode_btn  : back > alt > ok priority reduction
//   led_pattern : LED image for a state, given the number of failed PIN tries
package atm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_PIN_ENTRY  = 4'd1,
        ST_LOCK       = 4'd2,
        ST_MENU       = 4'd3,
        ST_MONEY      = 4'd4,
        ST_WARNING    = 4'd5,
        ST_CHG_VERIFY = 4'd6,
        ST_CHG_NEW    = 4'd7
    } state_e;

    typedef enum logic [1:0] {
        BTN_NONE = 2'd0,
        BTN_OK   = 2'd1,
        BTN_ALT  = 2'd2,
        BTN_BACK = 2'd3
    } btn_e;

    localparam logic [7:0] LED_IDLE     = 8'h01;
    localparam logic [7:0] LED_ALERT    = 8'hFF;
    localparam logic [7:0] LED_MENU     = 8'h10;
    localparam logic [7:0] LED_MONEY    = 8'h02;
    localparam logic [7:0] LED_CHG_NEW  = 8'h08;
    localparam logic [7:0] LED_PIN_BASE = 8'h80;
    localparam logic [7:0] LED_CHG_BASE = 8'h04;

    function automatic btn_e decode_btn(input logic ok, input logic alt, input logic back);
        if (back)
            return BTN_BACK;
        else if (alt)
            return BTN_ALT;
        else if (ok)
            return BTN_OK;
        else
            return BTN_NONE;
    endfunction

    // The low two bits of the thermometer already saturate at 2'b11 once
    // two or more tries have failed, which gives the capped CHG_VERIFY view.
    function automatic logic [7:0] led_pattern(input state_e s, input logic [2:0] failed);
        logic [6:0] therm;
        therm = 7'((8'd1 << failed) - 8'd1);
        case (s)
            ST_IDLE:       return LED_IDLE;
            ST_PIN_ENTRY:  return LED_PIN_BASE | {1'b0, therm};
            ST_LOCK:       return LED_ALERT;
            ST_MENU:       return LED_MENU;
            ST_MONEY:      return LED_MONEY;
            ST_WARNING:    return LED_ALERT;
            ST_CHG_VERIFY: return LED_CHG_BASE | {6'b0, therm[1:0]};
            ST_CHG_NEW:    return LED_CHG_NEW;
            default:       return LED_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/atm_timer.sv
// Loadable down-counter used for the LOCK/WARNING dwell and for inactivity.
//   clk, rst_n : clock and synchronous active-low reset (count returns to 0)
//   load       : capture value (has priority over en)
//   value      : reload value
//   en         : decrement by one
//   done       : count is zero
module atm_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= value;
        else if (en)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/atm_ctrl_gen2.sv
// ATM session controller: PIN entry with limited attempts, timed lockout,
// menu, deposit/withdraw with saturation, PIN change and inactivity logout.
//   clk, rst_n               : clock, synchronous active-low reset
//   btn_ok/btn_alt/btn_back  : one-cycle debounced button pulses
//   sw                       : PIN digits or transaction amount
//   state_o                  : current state code (atm_pkg::state_e)
//   tries_left               : PIN attempts remaining in the current entry phase
//   balance_o                : current balance
//   led                      : status LEDs, registered
//   sat_o                    : sticky deposit-saturation flag
module atm_ctrl_gen2
    import atm_pkg::*;
#(
    parameter int PIN_W       = 4,
    parameter int BAL_W       = 16,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYC    = 100,
    parameter int WARN_CYC    = 50,
    parameter int IDLE_TO_CYC = 0,
    parameter int DEFAULT_PIN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_ok,
    input  logic             btn_alt,
    input  logic             btn_back,
    input  logic [PIN_W-1:0] sw,
    output logic [3:0]       state_o,
    output logic [2:0]       tries_left,
    output logic [BAL_W-1:0] balance_o,
    output logic [7:0]       led,
    output logic             sat_o
);

    localparam int  TMAX    = (LOCK_CYC > WARN_CYC) ? LOCK_CYC : WARN_CYC;
    localparam int  TW      = $clog2(TMAX + 1);
    localparam int  IW      = $clog2(IDLE_TO_CYC + 2);
    localparam bit  IDLE_EN = (IDLE_TO_CYC != 0);

    state_e           state;
    btn_e             btn;
    logic [PIN_W-1:0] pin;
    logic [BAL_W-1:0] balance;
    logic [BAL_W-1:0] sw_ext;
    logic [BAL_W:0]   dep_sum;
    logic [2:0]       failed;
    logic             active;
    logic             seq_load, seq_en, seq_done;
    logic [TW-1:0]    seq_val;
    logic             idle_load, idle_en, idle_done, idle_timeout;
    logic [IW-1:0]    idle_val;

    assign btn     = decode_btn(btn_ok, btn_alt, btn_back);
    assign sw_ext  = BAL_W'(sw);
    assign dep_sum = {1'b0, balance} + {1'b0, sw_ext};
    assign failed  = 3'(MAX_TRIES) - tries_left;
    assign active  = state inside {ST_PIN_ENTRY, ST_MENU, ST_MONEY, ST_CHG_VERIFY, ST_CHG_NEW};

    // The dwell timer is reloaded every cycle outside LOCK/WARNING, so it
    // already holds the right count on the edge that enters either state.
    // WARNING is only reachable from MONEY; LOCK from the PIN states.
    assign seq_load = !(state == ST_LOCK || state == ST_WARNING);
    assign seq_en   = !seq_load && !seq_done;
    assign seq_val  = (state == ST_MONEY) ? TW'(WARN_CYC - 1) : TW'(LOCK_CYC - 1);

    atm_timer #(.W(TW)) u_seq_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seq_load),
        .value (seq_val),
        .en    (seq_en),
        .done  (seq_done)
    );

    // Inactivity: reloaded by any button or while in a non-timed state; the
    // timeout only fires on a button-free cycle so a button always wins.
    assign idle_load    = !active || (btn != BTN_NONE);
    assign idle_en      = !idle_load && !idle_done;
    assign idle_val     = IW'(IDLE_EN ? IDLE_TO_CYC - 1 : 0);
    assign idle_timeout = IDLE_EN && !idle_load && idle_done;

    atm_timer #(.W(IW)) u_idle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (idle_load),
        .value (idle_val),
        .en    (idle_en),
        .done  (idle_done)
    );

    // Session FSM with its datapath; led is updated alongside every state or
    // tries change so it is a pure register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pin        <= PIN_W'(DEFAULT_PIN);
            balance    <= '0;
            tries_left <= 3'(MAX_TRIES);
            sat_o      <= 1'b0;
            led        <= LED_IDLE;
        end else if (idle_timeout) begin
            state <= ST_IDLE;
            led   <= LED_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn == BTN_OK) begin
                        state      <= ST_PIN_ENTRY;
                        tries_left <= 3'(MAX_TRIES);
                        led        <= led_pattern(ST_PIN_ENTRY, 3'd0);
                    end
                end
                ST_PIN_ENTRY: begin
                    if (btn == BTN_BACK) begin
                        state <= ST_IDLE;
                        led   <= LED_IDLE;
                    end else if (btn == BTN_OK) begin
                        if (sw == pin) begin
                            state <= ST_MENU;
                            led   <= LED_MENU;
                        end else if (tries_left == 3'd1) begin
                            state <= ST_LOCK;
                            led   <= LED_ALERT;
                        end else begin
                            tries_left <= tries_left - 3'd1;
                            led        <= led_pattern(ST_PIN_ENTRY, failed + 3'd1);
                        end
                    end
                end
                ST_LOCK: begin
                    if (seq_done) begin
                        state <= ST_IDLE;
                        led   <= LED_IDLE;
                    end
                end
                ST_MENU: begin
                    if (btn == BTN_BACK) begin
                        state <= ST_IDLE;
                        led   <= LED_IDLE;
                    end else if (btn == BTN_ALT) begin
                        state      <= ST_CHG_VERIFY;
                        tries_left <= 3'(MAX_TRIES);
                        led        <= led_pattern(ST_CHG_VERIFY, 3'd0);
                    end else if (btn == BTN_OK) begin
                        state <= ST_MONEY;
                        led   <= LED_MONEY;
                    end
                end
                ST_MONEY: begin
                    if (btn == BTN_BACK) begin
                        state <= ST_MENU;
                        led   <= LED_MENU;
                    end else if (btn == BTN_ALT) begin
                        if (sw_ext <= balance) begin
                            balance <= balance - sw_ext;
                            sat_o   <= 1'b0;
                        end else begin
                            state <= ST_WARNING;
                            led   <= LED_ALERT;
                        end
                    end else if (btn == BTN_OK) begin
                        if (dep_sum[BAL_W]) begin
                            balance <= '1;
                            sat_o   <= 1'b1;
                        end else begin
                            balance <= dep_sum[BAL_W-1:0];
                        end
                    end
                end
                ST_WARNING: begin
                    if (seq_done) begin
                        state <= ST_MONEY;
                        led   <= LED_MONEY;
                    end
                end
                ST_CHG_VERIFY: begin
                    if (btn == BTN_BACK) begin
                        state <= ST_MENU;
                        led   <= LED_MENU;
                    end else if (btn == BTN_OK) begin
                        if (sw == pin) begin
                            state <= ST_CHG_NEW;
                            led   <= LED_CHG_NEW;
                        end else if (tries_left == 3'd1) begin
                            state <= ST_LOCK;
                            led   <= LED_ALERT;
                        end else begin
                            tries_left <= tries_left - 3'd1;
                            led        <= led_pattern(ST_CHG_VERIFY, failed + 3'd1);
                        end
                    end
                end
                ST_CHG_NEW: begin
                    if (btn == BTN_BACK) begin
                        state <= ST_MENU;
                        led   <= LED_MENU;
                    end else if (btn == BTN_OK) begin
                        pin   <= sw;
                        state <= ST_MENU;
                        led   <= LED_MENU;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    led   <= LED_IDLE;
                end
            endcase
        end
    end

    assign state_o   = state;
    assign balance_o = balance;

endmodule
